// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared types and constants for the LED pattern player and the other board
// blocks that reuse its prescaler.
//   state_t          : player FSM state (IDLE, RUN)
//   entry_t          : one table record {leds, dur} at the default widths
//   DEFAULT_TICK_DIV : clocks per tick at 50 MHz for a one-second tick
// -----------------------------------------------------------------------------
package led_seq_pkg;

    localparam int DEFAULT_TICK_DIV = 50_000_000;
    localparam int DEFAULT_NUM_LEDS = 8;
    localparam int DEFAULT_DEPTH    = 8;
    localparam int DEFAULT_DUR_W    = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Table record at the default board widths; the player stores the same
    // two fields as parallel arrays so that its widths stay parameterisable.
    typedef struct packed {
        logic [DEFAULT_NUM_LEDS-1:0] leds;
        logic [DEFAULT_DUR_W-1:0]    dur;
    } entry_t;

endpackage

// File: rtl/led_sequencer_if.sv
// -----------------------------------------------------------------------------
// led_sequencer_if
// Table write port of the LED pattern player (valid/ready).
//   wr_valid : host requests a table write
//   wr_ready : player accepts writes (only while idle)
//   wr_addr  : entry index
//   wr_leds  : entry LED pattern
//   wr_dur   : entry duration in ticks
// Modports: master = host side, slave = player side.
// -----------------------------------------------------------------------------
interface led_sequencer_if #(
    parameter int NUM_LEDS = led_seq_pkg::DEFAULT_NUM_LEDS,
    parameter int DEPTH    = led_seq_pkg::DEFAULT_DEPTH,
    parameter int DUR_W    = led_seq_pkg::DEFAULT_DUR_W
);

    logic                     wr_valid;
    logic                     wr_ready;
    logic [$clog2(DEPTH)-1:0] wr_addr;
    logic [NUM_LEDS-1:0]      wr_leds;
    logic [DUR_W-1:0]         wr_dur;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_leds,
        output wr_dur,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_leds,
        input  wr_dur,
        output wr_ready
    );

endinterface

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler producing a one-cycle tick every TICK_DIV enabled clocks.
//   clock  : system clock
//   reset  : synchronous, active-high reset
//   clear  : synchronous clear of the prescaler (wins over enable)
//   enable : count this cycle
//   tick   : high in the cycle the prescaler sits at TICK_DIV-1 while enabled
// -----------------------------------------------------------------------------
module tick_gen
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + CW'(1);
        end
    end

    assign tick = enable && !clear && (count_reg == LAST);

endmodule

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
// Programmable LED pattern player. Steps through a table of (pattern,
// duration) entries, each held for max(dur,1) prescaler ticks.
//   clock, reset : system clock, synchronous active-high reset
//   wr           : table write port (led_sequencer_if.slave)
//   last         : index of the final step, sampled on start
//   start        : begin playback (level, sampled while idle)
//   stop         : abort playback; also blocks start while idle
//   repeat_n     : extra passes, sampled on start (only with
//                  LED_SEQUENCER_REPEAT_EN defined)
//   leds         : current pattern (0 while idle)
//   step_idx     : current entry index
//   busy         : high while playing
//   done         : one-cycle pulse on natural completion
// Build option: define LED_SEQUENCER_REPEAT_EN to add repeat_n and a pass
// counter; without it every run is a single pass.
// -----------------------------------------------------------------------------
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int NUM_LEDS = DEFAULT_NUM_LEDS,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int DUR_W    = DEFAULT_DUR_W
) (
    input  logic                     clock,
    input  logic                     reset,
    led_sequencer_if.slave           wr,
    input  logic [$clog2(DEPTH)-1:0] last,
    input  logic                     start,
    input  logic                     stop,
`ifdef LED_SEQUENCER_REPEAT_EN
    input  logic [7:0]               repeat_n,
`endif
    output logic [NUM_LEDS-1:0]      leds,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);

    state_t              state_reg, state_next;
    logic [NUM_LEDS-1:0] tbl_leds_reg [DEPTH];
    logic [DUR_W-1:0]    tbl_dur_reg  [DEPTH];
    logic [DEPTH-1:0]    wr_sel;
    logic                wr_fire;

    logic [AW-1:0]       last_reg, last_next;
    logic [AW-1:0]       step_idx_reg, step_idx_next;
    logic [AW-1:0]       idx_inc;
    logic [DUR_W-1:0]    dur_cnt_reg, dur_cnt_next;
    logic [NUM_LEDS-1:0] leds_reg, leds_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                tick;

`ifdef LED_SEQUENCER_REPEAT_EN
    logic [7:0]          repeat_reg, repeat_next;
    logic [7:0]          pass_cnt_reg, pass_cnt_next;
`endif

    // A zero duration plays for one tick.
    function automatic logic [DUR_W-1:0] dur_or_one(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    // Writes only land while idle, so the table is frozen during playback.
    assign wr.wr_ready = (state_reg == IDLE);
    assign wr_fire     = wr.wr_valid && wr.wr_ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_fire && (wr.wr_addr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                tbl_leds_reg[i] <= '0;
                tbl_dur_reg[i]  <= '0;
            end else if (wr_sel[i]) begin
                tbl_leds_reg[i] <= wr.wr_leds;
                tbl_dur_reg[i]  <= wr.wr_dur;
            end
        end
    end

    // Prescaler held at zero while idle so every run starts on a full period.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_reg == IDLE),
        .enable (state_reg == RUN),
        .tick   (tick)
    );

    assign idx_inc = step_idx_reg + AW'(1);

    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        step_idx_next = step_idx_reg;
        dur_cnt_next  = dur_cnt_reg;
        leds_next     = leds_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
`ifdef LED_SEQUENCER_REPEAT_EN
        repeat_next   = repeat_reg;
        pass_cnt_next = pass_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                // Table reads here see the contents before any same-cycle write.
                if (start && !stop) begin
                    state_next    = RUN;
                    last_next     = last;
                    step_idx_next = '0;
                    leds_next     = tbl_leds_reg[0];
                    dur_cnt_next  = dur_or_one(tbl_dur_reg[0]);
                    busy_next     = 1'b1;
`ifdef LED_SEQUENCER_REPEAT_EN
                    repeat_next   = repeat_n;
                    pass_cnt_next = '0;
`endif
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                    leds_next  = '0;
                    busy_next  = 1'b0;
                end else if (tick) begin
                    if (dur_cnt_reg > DUR_W'(1)) begin
                        dur_cnt_next = dur_cnt_reg - DUR_W'(1);
                    end else if (step_idx_reg != last_reg) begin
                        step_idx_next = idx_inc;
                        leds_next     = tbl_leds_reg[idx_inc];
                        dur_cnt_next  = dur_or_one(tbl_dur_reg[idx_inc]);
                    end
`ifdef LED_SEQUENCER_REPEAT_EN
                    else if (pass_cnt_reg < repeat_reg) begin
                        // Next pass begins immediately, no idle gap.
                        pass_cnt_next = pass_cnt_reg + 8'd1;
                        step_idx_next = '0;
                        leds_next     = tbl_leds_reg[0];
                        dur_cnt_next  = dur_or_one(tbl_dur_reg[0]);
                    end
`endif
                    else begin
                        state_next = IDLE;
                        leds_next  = '0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                leds_next  = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_reg     <= '0;
            step_idx_reg <= '0;
            dur_cnt_reg  <= '0;
            leds_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef LED_SEQUENCER_REPEAT_EN
            repeat_reg   <= '0;
            pass_cnt_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            step_idx_reg <= step_idx_next;
            dur_cnt_reg  <= dur_cnt_next;
            leds_reg     <= leds_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
`ifdef LED_SEQUENCER_REPEAT_EN
            repeat_reg   <= repeat_next;
            pass_cnt_reg <= pass_cnt_next;
`endif
        end
    end

    assign leds     = leds_reg;
    assign step_idx = step_idx_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
// Self-checking bench for led_sequencer with TICK_DIV=4. A timeline model
// expands each accepted start into the full list of per-cycle outputs and is
// compared against the DUT every cycle; directed checks pin exact cycles.
// Define LED_SEQUENCER_REPEAT_EN to also exercise repeated passes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_sequencer;

    localparam int TD = 4;

    logic       clock;
    logic       reset;
    logic [2:0] last;
    logic       start;
    logic       stop;
    logic [7:0] repeat_n;
    logic [7:0] leds;
    logic [2:0] step_idx;
    logic       busy;
    logic       done;

    led_sequencer_if #(.NUM_LEDS(8), .DEPTH(8), .DUR_W(8)) wr_if ();

    led_sequencer #(
        .TICK_DIV (TD),
        .NUM_LEDS (8),
        .DEPTH    (8),
        .DUR_W    (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wr       (wr_if.slave),
        .last     (last),
        .start    (start),
        .stop     (stop),
`ifdef LED_SEQUENCER_REPEAT_EN
        .repeat_n (repeat_n),
`endif
        .leds     (leds),
        .step_idx (step_idx),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // ---------------- timeline model ----------------
    typedef struct packed {
        logic [7:0] leds;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t       cur;
    obs_t       sched[$];
    logic       model_ok = 1'b0;
    logic [7:0] m_leds [8];
    logic [7:0] m_dur  [8];

    task automatic build_schedule(input logic [2:0] lst, input int passes);
        obs_t e;
        int   cycles;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k <= int'(lst); k++) begin
                cycles = ((m_dur[k] == 8'd0) ? 1 : int'(m_dur[k])) * TD;
                for (int c = 0; c < cycles; c++) begin
                    e = '{leds: m_leds[k], idx: 3'(k), busy: 1'b1, done: 1'b0};
                    sched.push_back(e);
                end
            end
        end
        e = '{leds: 8'h00, idx: lst, busy: 1'b0, done: 1'b1};
        sched.push_back(e);
    endtask

    initial begin
        int passes;
        cur = '0;
        forever begin
            @(posedge clock);
            if (reset) begin
                for (int i = 0; i < 8; i++) begin
                    m_leds[i] = 8'h00;
                    m_dur[i]  = 8'h00;
                end
                sched.delete();
                cur = '0;
                model_ok = 1'b1;
            end else if (cur.busy) begin
                if (stop) begin
                    sched.delete();
                    cur = '{leds: 8'h00, idx: cur.idx, busy: 1'b0, done: 1'b0};
                end else begin
                    cur = sched.pop_front();
                end
            end else begin
                if (start && !stop) begin
`ifdef LED_SEQUENCER_REPEAT_EN
                    passes = int'(repeat_n) + 1;
`else
                    passes = 1;
`endif
                    build_schedule(last, passes);
                    cur = sched.pop_front();
                end else begin
                    cur = '{leds: 8'h00, idx: cur.idx, busy: 1'b0, done: 1'b0};
                end
                if (wr_if.wr_valid) begin
                    m_leds[wr_if.wr_addr] = wr_if.wr_leds;
                    m_dur[wr_if.wr_addr]  = wr_if.wr_dur;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (model_ok) begin
                checks++;
                if (leds !== cur.leds || step_idx !== cur.idx || busy !== cur.busy ||
                    done !== cur.done || wr_if.wr_ready !== !cur.busy) begin
                    errors++;
                    $display("FAIL cycle_cmp t=%0t got leds=%h idx=%0d busy=%b done=%b rdy=%b want leds=%h idx=%0d busy=%b done=%b rdy=%b",
                             $time, leds, step_idx, busy, done, wr_if.wr_ready,
                             cur.leds, cur.idx, cur.busy, cur.done, !cur.busy);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [7:0] l, input logic [7:0] d);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = a;
        wr_if.wr_leds  = l;
        wr_if.wr_dur   = d;
        cyc(1);
        wr_if.wr_valid = 1'b0;
        $display("write addr=%0d leds=%h dur=%0d", a, l, d);
    endtask

    // Drives start for one sampling edge; returns at the t+1 observation point.
    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        stop           = 1'b0;
        last           = 3'd0;
        repeat_n       = 8'd0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = 3'd0;
        wr_if.wr_leds  = 8'h00;
        wr_if.wr_dur   = 8'h00;
        cyc(2);
        chk("rst_leds", 32'(leds), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(wr_if.wr_ready), 32'h1);
        chk("rst_idx", 32'(step_idx), 32'h0);
        reset = 1'b0;
        $display("reset released");

        // Simple play: {01,2},{02,1}, last=1.
        write_entry(3'd0, 8'h01, 8'd2);
        write_entry(3'd1, 8'h02, 8'd1);
        last = 3'd1;
        pulse_start();
        chk("play_t1_leds", 32'(leds), 32'h01);
        chk("play_t1_busy", 32'(busy), 32'h1);
        cyc(7);
        chk("play_t8_leds", 32'(leds), 32'h01);
        cyc(1);
        chk("play_t9_leds", 32'(leds), 32'h02);
        chk("play_t9_idx", 32'(step_idx), 32'h1);
        cyc(3);
        chk("play_t12_leds", 32'(leds), 32'h02);
        cyc(1);
        chk("play_t13_done", 32'(done), 32'h1);
        chk("play_t13_leds", 32'(leds), 32'h00);
        cyc(1);
        chk("play_t14_done", 32'(done), 32'h0);
        $display("simple play complete");

        // Zero duration plays one tick.
        write_entry(3'd0, 8'hFF, 8'd0);
        last = 3'd0;
        pulse_start();
        chk("zero_t1_leds", 32'(leds), 32'hFF);
        cyc(3);
        chk("zero_t4_leds", 32'(leds), 32'hFF);
        cyc(1);
        chk("zero_t5_done", 32'(done), 32'h1);
        $display("zero duration complete");

        // Start held through done restarts one cycle later.
        start = 1'b1;
        cyc(5);
        chk("hold_t5_done", 32'(done), 32'h1);
        cyc(1);
        chk("hold_t6_busy", 32'(busy), 32'h1);
        start = 1'b0;
        stop  = 1'b1;
        cyc(1);
        stop  = 1'b0;
        chk("hold_stop_busy", 32'(busy), 32'h0);
        $display("held start restart complete");

        // Stop mid-step.
        write_entry(3'd0, 8'h01, 8'd2);
        last = 3'd1;
        pulse_start();
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'h0);
        chk("stop_leds", 32'(leds), 32'h00);
        chk("stop_done", 32'(done), 32'h0);
        cyc(20);
        pulse_start();
        chk("restart_leds", 32'(leds), 32'h01);
        chk("restart_idx", 32'(step_idx), 32'h0);
        cyc(12);
        chk("restart_done", 32'(done), 32'h1);
        $display("stop mid-step complete");

        // Write stalled during RUN, accepted on the done cycle.
        pulse_start();
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = 3'd0;
        wr_if.wr_leds  = 8'hAA;
        wr_if.wr_dur   = 8'd3;
        cyc(1);
        chk("stall_ready", 32'(wr_if.wr_ready), 32'h0);
        cyc(10);
        chk("stall_t12_leds", 32'(leds), 32'h02);
        cyc(1);
        chk("stall_t13_done", 32'(done), 32'h1);
        chk("stall_t13_ready", 32'(wr_if.wr_ready), 32'h1);
        cyc(1);
        wr_if.wr_valid = 1'b0;
        pulse_start();
        chk("wr_t1_leds", 32'(leds), 32'hAA);
        cyc(11);
        chk("wr_t12_leds", 32'(leds), 32'hAA);
        cyc(1);
        chk("wr_t13_leds", 32'(leds), 32'h02);
        cyc(4);
        chk("wr_t17_done", 32'(done), 32'h1);
        $display("write stall complete");

        // start and stop together while idle.
        start = 1'b1;
        stop  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("startstop_busy", 32'(busy), 32'h0);
        end
        start = 1'b0;
        stop  = 1'b0;
        $display("start+stop idle complete");

`ifdef LED_SEQUENCER_REPEAT_EN
        write_entry(3'd0, 8'h5A, 8'd1);
        last     = 3'd0;
        repeat_n = 8'd2;
        pulse_start();
        chk("rep_t1_leds", 32'(leds), 32'h5A);
        cyc(4);
        chk("rep_t5_busy", 32'(busy), 32'h1);
        cyc(7);
        chk("rep_t12_leds", 32'(leds), 32'h5A);
        cyc(1);
        chk("rep_t13_done", 32'(done), 32'h1);
        repeat_n = 8'd0;
        $display("repeat complete");
`endif

        cyc(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
